cpu_program_loader: RTL



---
 rtl/cpu_loader_pkg.sv | 17 +
 rtl/cpu_program_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the CPU program loader.
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CNT,
    LO,
    HI,
    CSUM,
    RELEASE
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         INSTR_BYTES       = 2;

endpackage

// File: rtl/cpu_program_loader.sv
// Parses SYNC/START/COUNT/payload[/CSUM] packets and writes LE words into CPU instruction memory.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module cpu_program_loader
  import cpu_loader_pkg::*;
#(
  parameter int         ADDR_W         = 8,
  parameter int         INSTR_W        = 8 * INSTR_BYTES,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         RELEASE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               cpu_hold,
  output logic [ADDR_W-1:0]  write_instruction_index,
  output logic [INSTR_W-1:0] write_instruction,
  output logic               instr_we,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int               REL_W   = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);
  localparam logic [REL_W-1:0] REL_MAX = REL_W'(RELEASE_CYCLES);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  widx_q, widx_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [7:0]         lo_q, lo_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [REL_W-1:0]   rel_q, rel_d;
  logic               we_q, we_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
  logic               err_q, err_d;
`endif

  assign in_ready = (state_q != RELEASE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    widx_d  = widx_q;
    instr_d = instr_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    done_d  = 1'b0;
    // Saturating count of cycles since the most recent word write
    rel_d   = (rel_q == REL_MAX) ? rel_q : rel_q + REL_W'(1);
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
    if (accept && (state_q inside {ADDR, CNT, LO, HI})) csum_d = csum_q ^ in_data;
`endif
    case (state_q)
      IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = ADDR;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
          err_d   = 1'b0;
`endif
        end
      end
      ADDR: begin
        if (accept) begin
          addr_d  = ADDR_W'(in_data);
          state_d = CNT;
        end
      end
      CNT: begin
        if (accept) begin
          cnt_d = in_data;
          if (in_data == 8'd0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LO;
          end
        end
      end
      LO: begin
        if (accept) begin
          lo_d    = in_data;
          state_d = HI;
        end
      end
      HI: begin
        if (accept) begin
          instr_d = INSTR_W'({in_data, lo_q});
          widx_d  = addr_q;
          addr_d  = addr_q + ADDR_W'(1);
          we_d    = 1'b1;
          hold_d  = 1'b1;
          rel_d   = '0;
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = RELEASE;
`endif
          end else begin
            state_d = LO;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        // A bad image keeps the CPU held so it never executes it
        if (accept) begin
          if (in_data == csum_q) begin
            err_d   = 1'b0;
            state_d = RELEASE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      RELEASE: begin
        if (rel_q == REL_MAX) begin
          hold_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      widx_q  <= '0;
      instr_q <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      rel_q   <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      widx_q  <= widx_d;
      instr_q <= instr_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign write_instruction_index = widx_q;
  assign write_instruction       = instr_q;
  assign instr_we                = we_q;
  assign cpu_hold                = hold_q;
  assign done                    = done_q;
  assign busy                    = (state_q != IDLE);
`ifdef LOADER_CHECKSUM_EN
  assign error                   = err_q;
`else
  assign error                   = 1'b0;
`endif

endmodule
